// File: rtl/fp_check_pkg.sv
// Shared FSM encoding and IEEE-754 single-precision helpers for the FP vector BIST.
// Purely declarative: no latency and no backpressure of its own.
package fp_check_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int          SIGN_BIT = 31;
  localparam int          EXP_MSB  = 30;
  localparam int          EXP_LSB  = 23;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  // The exponent field of QNAN is all ones, which is exactly the NaN/Inf exponent.
  function automatic logic is_nan(input logic [31:0] x);
    return (x[EXP_MSB:EXP_LSB] == QNAN[EXP_MSB:EXP_LSB]) && (x[EXP_LSB-1:0] != '0);
  endfunction

  // Monotonic integer key: adjacent floats map to adjacent keys, -0 sits just below +0.
  function automatic logic [31:0] ord_key(input logic [31:0] x);
    return x[SIGN_BIT] ? ~x : (x ^ 32'h8000_0000);
  endfunction

endpackage

// File: rtl/fp_ulp_compare.sv
// Result scoring: bit-exact equality, or ULP-distance match when FP_ULP_TOL_EN is defined.
// Combinational, zero latency; no backpressure.
// NaN handling under FP_ULP_TOL_EN: both NaN match, exactly one NaN is a mismatch.
module fp_ulp_compare
  import fp_check_pkg::*;
(
  input  logic [31:0] result,
  input  logic [31:0] expected,
  input  logic [31:0] tol,
  output logic        match
);

`ifdef FP_ULP_TOL_EN
  logic [32:0] diff;
  logic [32:0] dist;
  logic        nan_r;
  logic        nan_e;

  always_comb begin
    nan_r = is_nan(result);
    nan_e = is_nan(expected);
    diff  = {1'b0, ord_key(result)} - {1'b0, ord_key(expected)};
    dist  = diff[32] ? (~diff + 33'd1) : diff;
    match = (nan_r && nan_e) || (!nan_r && !nan_e && (dist <= {1'b0, tol}));
  end
`else
  logic unused_tol;
  assign unused_tol = ^tol;
  assign match      = (result == expected);
`endif

endmodule

// File: rtl/fp_vector_initiator.sv
// FP datapath BIST initiator: ROM vector -> FP unit start/busy/valid -> score (FP_ULP_TOL_EN selects ULP scoring).
// Latency: FP unit latency + 5 cycles per vector; a silent unit is scored as an error after TIMEOUT_CYC cycles.
// Backpressure: op_start is withheld while op_busy is high; abort returns to IDLE from any state.
module fp_vector_initiator
  import fp_check_pkg::*;
#(
  parameter int IDX_W       = 17,
  parameter int TIMEOUT_CYC = 64,
  parameter int ULP_TOL     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             abort,
  input  logic [IDX_W-1:0] num_vectors,
  output logic [IDX_W-1:0] vec_addr,
  input  logic [31:0]      vec_a,
  input  logic [31:0]      vec_b,
  input  logic [31:0]      vec_exp,
  output logic [31:0]      op_a,
  output logic [31:0]      op_b,
  output logic             op_start,
  input  logic             op_busy,
  input  logic             op_valid,
  input  logic [31:0]      op_result,
  output logic             done,
  output logic [IDX_W-1:0] pass_cnt,
  output logic [IDX_W-1:0] err_cnt,
  output logic [IDX_W-1:0] first_err_idx,
  output logic [31:0]      first_err_got,
  output logic             err_seen
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] num_q;
  logic [31:0]      exp_q;
  logic [31:0]      got_q;
  logic             tmo_err_q;
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit;
  logic             last_vec;
  logic             cmp_match;
  logic             vec_ok;

  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign last_vec = (idx_q == num_q - 1'b1);
  assign vec_ok   = !tmo_err_q && cmp_match;
  assign vec_addr = idx_q;

  fp_ulp_compare u_cmp (
    .result   (got_q),
    .expected (exp_q),
    .tol      (32'(ULP_TOL)),
    .match    (cmp_match)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: if (run) state_d = (num_vectors == '0) ? S_DONE : S_FETCH;
        S_FETCH:        state_d = S_LOAD;
        S_LOAD:         state_d = S_ISSUE;
        S_ISSUE:        if (!op_busy) state_d = S_WAIT;
        S_WAIT:         if (op_valid || tmo_hit) state_d = S_CHECK;
        S_CHECK:        state_d = last_vec ? S_DONE : S_FETCH;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // Gating with abort keeps the FP unit from being kicked on the way back to IDLE.
  always_comb begin
    op_start = (state_q == S_ISSUE) && !op_busy && !abort;
    done     = (state_q == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q         <= '0;
      num_q         <= '0;
      op_a          <= '0;
      op_b          <= '0;
      exp_q         <= '0;
      got_q         <= '0;
      tmo_err_q     <= 1'b0;
      tmo_q         <= '0;
      pass_cnt      <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_got <= '0;
      err_seen      <= 1'b0;
    end else if (!abort) begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (run) begin
            num_q         <= num_vectors;
            idx_q         <= '0;
            pass_cnt      <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
            err_seen      <= 1'b0;
          end
        end
        S_LOAD: begin
          op_a  <= vec_a;
          op_b  <= vec_b;
          exp_q <= vec_exp;
        end
        S_ISSUE: tmo_q <= '0;
        S_WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          if (op_valid) begin
            got_q     <= op_result;
            tmo_err_q <= 1'b0;
          end else if (tmo_hit) begin
            got_q     <= '0;
            tmo_err_q <= 1'b1;
          end
        end
        S_CHECK: begin
          if (vec_ok) begin
            pass_cnt <= sat_inc(pass_cnt);
          end else begin
            err_cnt <= sat_inc(err_cnt);
            if (!err_seen) begin
              first_err_idx <= idx_q;
              first_err_got <= got_q;
              err_seen      <= 1'b1;
            end
          end
          if (!last_vec) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_vector_initiator.sv
// Bench for fp_vector_initiator: table-driven ROM and FP-unit responder, campaign-level reference scoring.
module tb_fp_vector_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        abort;
  logic [16:0] num_vectors;
  logic [16:0] vec_addr;
  logic [31:0] vec_a, vec_b, vec_exp;
  logic [31:0] op_a, op_b;
  logic        op_start;
  logic        op_busy;
  logic        op_valid;
  logic [31:0] op_result;
  logic        done;
  logic [16:0] pass_cnt, err_cnt, first_err_idx;
  logic [31:0] first_err_got;
  logic        err_seen;
  logic        force_busy;

  always #5 clk = ~clk;

  fp_vector_initiator dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .abort         (abort),
    .num_vectors   (num_vectors),
    .vec_addr      (vec_addr),
    .vec_a         (vec_a),
    .vec_b         (vec_b),
    .vec_exp       (vec_exp),
    .op_a          (op_a),
    .op_b          (op_b),
    .op_start      (op_start),
    .op_busy       (op_busy),
    .op_valid      (op_valid),
    .op_result     (op_result),
    .done          (done),
    .pass_cnt      (pass_cnt),
    .err_cnt       (err_cnt),
    .first_err_idx (first_err_idx),
    .first_err_got (first_err_got),
    .err_seen      (err_seen)
  );

  // Vector ROM contents plus per-vector FP unit behaviour (result, dropped valid, latency).
  logic [31:0] a_tab [16];
  logic [31:0] b_tab [16];
  logic [31:0] e_tab [16];
  logic [31:0] r_tab [16];
  bit          d_tab [16];
  int          l_tab [16];

  always @(posedge clk) begin
    vec_a   <= a_tab[vec_addr[3:0]];
    vec_b   <= b_tab[vec_addr[3:0]];
    vec_exp <= e_tab[vec_addr[3:0]];
  end

  int          fp_left;
  bit          fp_drop;
  logic [31:0] fp_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fp_left   <= 0;
      fp_drop   <= 1'b0;
      fp_res    <= '0;
      op_valid  <= 1'b0;
      op_result <= '0;
    end else begin
      op_valid <= 1'b0;
      if (op_start) begin
        fp_res  <= r_tab[vec_addr[3:0]];
        fp_drop <= d_tab[vec_addr[3:0]];
        fp_left <= l_tab[vec_addr[3:0]];
      end else if (fp_left > 0) begin
        fp_left <= fp_left - 1;
        if (fp_left == 1 && !fp_drop) begin
          op_valid  <= 1'b1;
          op_result <= fp_res;
        end
      end
    end
  end

  assign op_busy = force_busy || (fp_left > 0);

  int start_cnt = 0, cur_run = 0, max_run = 0, start_busy = 0, opnd_bad = 0;

  always @(posedge clk) begin
    if (op_start) begin
      start_cnt++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      if (op_busy) start_busy++;
      if (op_a !== a_tab[vec_addr[3:0]] || op_b !== b_tab[vec_addr[3:0]]) opnd_bad++;
    end else begin
      cur_run = 0;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit ref_match(input logic [31:0] r, input logic [31:0] e);
`ifdef FP_ULP_TOL_EN
    bit     nr, ne;
    longint kr, ke, dd;
    nr = (r[30:23] == 8'hFF) && (r[22:0] != 0);
    ne = (e[30:23] == 8'hFF) && (e[22:0] != 0);
    if (nr || ne) return nr && ne;
    kr = longint'(r[31] ? ~r : (r ^ 32'h8000_0000));
    ke = longint'(e[31] ? ~e : (e ^ 32'h8000_0000));
    dd = kr - ke;
    if (dd < 0) dd = -dd;
    return dd <= 1;
`else
    return r === e;
`endif
  endfunction

  int          e_pass, e_err, e_fidx;
  logic [31:0] e_fgot;
  bit          e_seen;

  task automatic ref_model(input int n);
    e_pass = 0; e_err = 0; e_fidx = 0; e_fgot = '0; e_seen = 0;
    for (int i = 0; i < n; i++) begin
      if (!d_tab[i] && ref_match(r_tab[i], e_tab[i])) begin
        e_pass++;
      end else begin
        e_err++;
        if (!e_seen) begin
          e_seen = 1;
          e_fidx = i;
          e_fgot = d_tab[i] ? 32'h0 : r_tab[i];
        end
      end
    end
  endtask

  task automatic fill_pass(input int n, input int lat);
    for (int i = 0; i < 16; i++) begin
      a_tab[i] = $urandom; b_tab[i] = $urandom; e_tab[i] = $urandom;
      r_tab[i] = e_tab[i]; d_tab[i] = 0; l_tab[i] = lat;
    end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < 16; i++) begin
      a_tab[i] = $urandom; b_tab[i] = $urandom; e_tab[i] = $urandom;
      case ($urandom_range(0, 3))
        0:       r_tab[i] = e_tab[i] ^ (32'h1 << $urandom_range(0, 31));
        1:       r_tab[i] = e_tab[i] + 32'd1;
        default: r_tab[i] = e_tab[i];
      endcase
      d_tab[i] = ($urandom_range(0, 7) == 0);
      l_tab[i] = $urandom_range(1, 8);
    end
  endtask

  task automatic start_run(input int n);
    @(negedge clk);
    num_vectors = 17'(n);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int c = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_wait_at(input int a, input string tag);
    int c = 0;
    while (!(vec_addr == 17'(a) && op_busy) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(c < 2000), 32'd1);
  endtask

  task automatic check_results(input int n, input string tag);
    ref_model(n);
    chk({tag, "_pass"}, 32'(pass_cnt), 32'(e_pass));
    chk({tag, "_err"}, 32'(err_cnt), 32'(e_err));
    chk({tag, "_seen"}, 32'(err_seen), 32'(e_seen));
    chk({tag, "_fidx"}, 32'(first_err_idx), 32'(e_fidx));
    chk({tag, "_fgot"}, first_err_got, e_fgot);
  endtask

  task automatic campaign(input int n, input string tag);
    start_run(n);
    wait_done(100 * n + 20, {tag, "_done"});
    check_results(n, tag);
  endtask

  initial begin
    int s0;
    rst = 1'b1; run = 1'b0; abort = 1'b0; num_vectors = '0; force_busy = 1'b0;
    fill_pass(16, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass_cnt), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_seen", 32'(err_seen), 32'd0);
    chk("rst_addr", 32'(vec_addr), 32'd0);
    chk("rst_start", 32'(op_start), 32'd0);
    chk("rst_opa", op_a, 32'd0);

    // One real addition: 1.0 + 1.0 = 2.0.
    fill_pass(1, 2);
    a_tab[0] = 32'h3F80_0000; b_tab[0] = 32'h3F80_0000;
    e_tab[0] = 32'h4000_0000; r_tab[0] = 32'h4000_0000;
    campaign(1, "one");

    fill_pass(10, 3);
    e_tab[5] = 32'h4000_0000; r_tab[5] = 32'h4000_0001;
    campaign(10, "ulp5");

    fill_pass(4, 3);
    d_tab[2] = 1;
    campaign(4, "tmo2");

    fill_pass(1, 2);
    force_busy = 1'b1;
    start_run(1);
    s0 = start_cnt;
    repeat (20) @(negedge clk);
    chk("busy_no_start", 32'(start_cnt - s0), 32'd0);
    force_busy = 1'b0;
    wait_done(200, "busy_done");
    chk("busy_one_start", 32'(start_cnt - s0), 32'd1);
    check_results(1, "busy");

    s0 = start_cnt;
    @(negedge clk);
    num_vectors = '0;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_no_start", 32'(start_cnt - s0), 32'd0);
    chk("zero_pass", 32'(pass_cnt), 32'd0);

    fill_pass(8, 4);
    start_run(8);
    wait_wait_at(3, "abort_reach");
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    s0 = start_cnt;
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_pass", 32'(pass_cnt), 32'd3);
    repeat (20) @(negedge clk);
    chk("abort_hold_pass", 32'(pass_cnt), 32'd3);
    chk("abort_hold_done", 32'(done), 32'd0);
    chk("abort_no_start", 32'(start_cnt - s0), 32'd0);

    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 16);
      fill_rand(n);
      campaign(n, $sformatf("rand%0d", k));
    end

    fill_pass(4, 8);
    start_run(4);
    wait_wait_at(1, "rst_reach");
    chk("rst_pre_pass", 32'(pass_cnt), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_pass", 32'(pass_cnt), 32'd0);
    chk("rst_mid_start", 32'(op_start), 32'd0);
    chk("rst_mid_addr", 32'(vec_addr), 32'd0);
    chk("rst_mid_opa", op_a, 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    s0 = start_cnt;
    repeat (30) @(negedge clk);
    chk("rst_no_start", 32'(start_cnt - s0), 32'd0);
    chk("rst_idle_done", 32'(done), 32'd0);

    chk("start_width", 32'(max_run), 32'd1);
    chk("start_while_busy", 32'(start_busy), 32'd0);
    chk("operand_path", 32'(opnd_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
